// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Purpose  : Shared constants and helpers for the FP adder pipeline stages.
//            Rounding-mode encodings, exponent limits, canonical special
//            encodings and the round-increment decision.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam logic [1:0]  RM_RNE     = 2'b00;  // nearest, ties to even
    localparam logic [1:0]  RM_RDN     = 2'b01;  // toward -inf
    localparam logic [1:0]  RM_RUP     = 2'b10;  // toward +inf
    localparam logic [1:0]  RM_RTZ     = 2'b11;  // toward zero

    localparam logic [7:0]  EXP_MAX    = 8'hff;
    localparam logic [31:0] QNAN       = 32'h7fc0_0000;
    localparam logic [30:0] MAX_FINITE = 31'h7f7f_ffff;  // magnitude only

    // Decide whether the truncated significand must be incremented.
    function automatic logic round_inc(input logic [1:0] rm,
                                       input logic       sign,
                                       input logic       lsb,
                                       input logic       g,
                                       input logic       r,
                                       input logic       s);
        logic inexact;
        inexact = g | r | s;
        case (rm)
            RM_RNE:  round_inc = g & (r | s | lsb);
            RM_RDN:  round_inc = sign & inexact;
            RM_RUP:  round_inc = ~sign & inexact;
            default: round_inc = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/fadd_lzc28.sv
`default_nettype none
// ============================================================================
// Module   : fadd_lzc28
// Purpose  : Combinational leading-zero counter over a 28-bit vector.
// Ports    : d   [27:0] in  - vector to scan, MSB first
//            cnt [4:0]  out - number of zeros above the first set bit
//                             (28 when d is all zero)
// Revision : 1.0 - initial release
// ============================================================================
module fadd_lzc28 (
    input  logic [27:0] d,
    output logic [4:0]  cnt
);

    logic w_found;

    always_comb begin
        cnt     = 5'd28;
        w_found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!w_found && d[i]) begin
                cnt     = 5'(27 - i);
                w_found = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fadd_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : fadd_norm_round
// Purpose  : Normalize/round stage of the pipelined FP adder. Turns the
//            calc-stage fields into a packed IEEE-754 single result and
//            holds it in a main register plus an optional skid register
//            behind a valid/ready handshake.
// Ports    : clk, clrn (sync active-low reset), flush (drop buffered results)
//            in_valid/in_ready, in_frac[27:0], in_exp[7:0], in_rm[1:0],
//            in_sign, in_is_nan, in_is_inf, in_inf_nan_frac[22:0]
//            out_valid/out_ready, out_result[31:0], out_ovf
// Revision : 1.0 - initial release
// ============================================================================
module fadd_norm_round
    import fpu_pkg::*;
#(
    parameter int SKID = 1
) (
    input  logic        clk,
    input  logic        clrn,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [27:0] in_frac,
    input  logic [7:0]  in_exp,
    input  logic [1:0]  in_rm,
    input  logic        in_sign,
    input  logic        in_is_nan,
    input  logic        in_is_inf,
    input  logic [22:0] in_inf_nan_frac,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf
);

    // ------------------------------------------------------------------
    // Normalize
    // ------------------------------------------------------------------
    logic [4:0]  w_z;
    logic [4:0]  w_shamt;
    logic [26:0] w_n;        // {hidden, fraction[22:0], G, R, S}
    logic [9:0]  w_en;       // wide so exponent overflow stays visible

    fadd_lzc28 u_lzc (
        .d   ({in_frac[26:0], 1'b1}),  // sentinel caps the count at 27
        .cnt (w_z)
    );

    always_comb begin
        w_n     = '0;
        w_en    = '0;
        w_shamt = '0;
        if (in_frac[27]) begin
            // Carry out of the add: shift right, fold the lost bit into S.
            w_n  = {in_frac[27:2], in_frac[1] | in_frac[0]};
            w_en = {2'b00, in_exp} + 10'd1;
        end else if (in_exp == 8'd0) begin
            w_n  = in_frac[26:0];
        end else if ({3'b000, w_z} < in_exp) begin
            w_n  = in_frac[26:0] << w_z;
            w_en = {2'b00, in_exp} - {5'b00000, w_z};
        end else begin
            // Cannot reach a hidden 1 without underflowing: go denormal.
            // Here in_exp <= w_z <= 27, so the amount fits in 5 bits.
            w_shamt = 5'(in_exp - 8'd1);
            w_n     = in_frac[26:0] << w_shamt;
        end
    end

    // ------------------------------------------------------------------
    // Round
    // ------------------------------------------------------------------
    logic        w_inc;
    logic [24:0] w_sum;
    logic [23:0] w_sig_r;
    logic [9:0]  w_er;

    assign w_inc = round_inc(in_rm, in_sign, w_n[3], w_n[2], w_n[1], w_n[0]);
    assign w_sum = {1'b0, w_n[26:3]} + {24'd0, w_inc};

    always_comb begin
        w_sig_r = w_sum[23:0];
        w_er    = w_en;
        if (w_sum[24]) begin
            w_sig_r = w_sum[24:1];
            w_er    = w_en + 10'd1;
        end else if (w_en == 10'd0 && w_sum[23]) begin
            // Denormal rounded up into the hidden bit: smallest normal.
            w_er = 10'd1;
        end
    end

    // ------------------------------------------------------------------
    // Result selection: NaN > Inf > zero > overflow > normal
    // ------------------------------------------------------------------
    logic [31:0] w_result;
    logic        w_ovf;
    logic        w_to_inf;

    assign w_to_inf = (in_rm == RM_RNE) ||
                      (in_rm == RM_RDN &&  in_sign) ||
                      (in_rm == RM_RUP && !in_sign);

    always_comb begin
        w_ovf    = 1'b0;
        w_result = {in_sign, w_er[7:0], w_sig_r[22:0]};
        if (in_is_nan) begin
            w_result = {in_sign, EXP_MAX, in_inf_nan_frac};
        end else if (in_is_inf) begin
            w_result = {in_sign, EXP_MAX, 23'h0};
        end else if (in_frac == 28'd0) begin
            w_result = {in_sign, 31'h0};
        end else if (w_er >= {2'b00, EXP_MAX}) begin
            w_ovf    = 1'b1;
            w_result = w_to_inf ? {in_sign, EXP_MAX, 23'h0}
                                : {in_sign, MAX_FINITE};
        end
    end

    // ------------------------------------------------------------------
    // Main + skid output buffer
    // ------------------------------------------------------------------
    logic        r_main_valid;
    logic [31:0] r_main_result;
    logic        r_main_ovf;
    logic        r_skid_valid;
    logic [31:0] r_skid_result;
    logic        r_skid_ovf;
    logic        w_in_fire;
    logic        w_out_fire;

    generate
        if (SKID != 0) begin : g_skid
            assign in_ready = !r_skid_valid;
        end else begin : g_noskid
            assign in_ready = !r_main_valid || out_ready;
        end
    endgenerate

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_main_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!clrn) begin
            r_main_valid  <= 1'b0;
            r_main_result <= '0;
            r_main_ovf    <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_ovf    <= 1'b0;
        end else if (flush) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_main_valid || w_out_fire) begin
            if (r_skid_valid) begin
                // in_ready is low while the skid is occupied, so no new
                // input can compete with the refill.
                r_main_valid  <= 1'b1;
                r_main_result <= r_skid_result;
                r_main_ovf    <= r_skid_ovf;
                r_skid_valid  <= 1'b0;
            end else if (w_in_fire) begin
                r_main_valid  <= 1'b1;
                r_main_result <= w_result;
                r_main_ovf    <= w_ovf;
            end else begin
                r_main_valid  <= 1'b0;
            end
        end else if (w_in_fire && SKID != 0) begin
            r_skid_valid  <= 1'b1;
            r_skid_result <= w_result;
            r_skid_ovf    <= w_ovf;
        end
    end

    assign out_valid  = r_main_valid;
    assign out_result = r_main_result;
    assign out_ovf    = r_main_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fadd_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : tb_fadd_norm_round
// Purpose  : Self-checking bench for fadd_norm_round. Directed vectors with
//            hand-computed results feed a scoreboard queue; a monitor pops
//            and compares whenever an output transfer happens.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fadd_norm_round;

    logic        clk = 1'b0;
    logic        clrn = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [27:0] in_frac = '0;
    logic [7:0]  in_exp = '0;
    logic [1:0]  in_rm = '0;
    logic        in_sign = 1'b0;
    logic        in_is_nan = 1'b0;
    logic        in_is_inf = 1'b0;
    logic [22:0] in_inf_nan_frac = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic        out_ovf;

    fadd_norm_round #(.SKID(1)) dut (
        .clk             (clk),
        .clrn            (clrn),
        .flush           (flush),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_frac         (in_frac),
        .in_exp          (in_exp),
        .in_rm           (in_rm),
        .in_sign         (in_sign),
        .in_is_nan       (in_is_nan),
        .in_is_inf       (in_is_inf),
        .in_inf_nan_frac (in_inf_nan_frac),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_result      (out_result),
        .out_ovf         (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  exp;
        logic [27:0] frac;
        logic [1:0]  rm;
        logic        sign;
        logic        nan;
        logic        inf;
        logic [22:0] pay;
        logic [31:0] res;
        logic        ovf;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb[$];     // {result, ovf}
    int          n_total = 0;
    int          n_bad   = 0;
    logic        rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] e, input logic [27:0] f, input logic [1:0] rm,
                                input logic s, input logic nan, input logic inf,
                                input logic [22:0] pay, input logic [31:0] res, input logic ovf);
        vec_t v;
        v.exp = e; v.frac = f; v.rm = rm; v.sign = s; v.nan = nan; v.inf = inf;
        v.pay = pay; v.res = res; v.ovf = ovf;
        return v;
    endfunction

    // Called at posedge+1; returns at the posedge+1 after the transfer edge.
    task automatic send(input vec_t v);
        int n;
        in_valid = 1'b1; in_exp = v.exp; in_frac = v.frac; in_rm = v.rm;
        in_sign = v.sign; in_is_nan = v.nan; in_is_inf = v.inf; in_inf_nan_frac = v.pay;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_total++; n_bad++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1");
        end else if (!flush && clrn) begin
            sb.push_back({v.res, v.ovf});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Monitor: an output transfer happens at the next edge when both are high.
    initial begin
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (clrn && !flush && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++; n_bad++;
                    $display("FAIL sb_extra: got %h expected no output", {out_result, out_ovf});
                end else begin
                    e = sb.pop_front();
                    chk("sb_result", {out_result, out_ovf}, e);
                end
            end
        end
    end

    // Random backpressure for the stream phase.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int n;
        vecs.push_back(mk(8'h7f, 28'h8000000, 2'd0, 0, 0, 0, 23'h0,      32'h40000000, 0));
        vecs.push_back(mk(8'h7f, 28'h0800000, 2'd0, 0, 0, 0, 23'h0,      32'h3e000000, 0));
        vecs.push_back(mk(8'h02, 28'h0000800, 2'd0, 0, 0, 0, 23'h0,      32'h00000200, 0));
        vecs.push_back(mk(8'h7f, 28'h4000004, 2'd0, 0, 0, 0, 23'h0,      32'h3f800000, 0));
        vecs.push_back(mk(8'h7f, 28'h4000004, 2'd2, 0, 0, 0, 23'h0,      32'h3f800001, 0));
        vecs.push_back(mk(8'h7f, 28'h4000004, 2'd1, 1, 0, 0, 23'h0,      32'hbf800001, 0));
        vecs.push_back(mk(8'h7f, 28'h4000004, 2'd3, 0, 0, 0, 23'h0,      32'h3f800000, 0));
        vecs.push_back(mk(8'hfe, 28'h8000000, 2'd0, 0, 0, 0, 23'h0,      32'h7f800000, 1));
        vecs.push_back(mk(8'hfe, 28'h8000000, 2'd3, 0, 0, 0, 23'h0,      32'h7f7fffff, 1));
        vecs.push_back(mk(8'h7f, 28'h4000000, 2'd0, 0, 1, 0, 23'h400000, 32'h7fc00000, 0));
        vecs.push_back(mk(8'h7f, 28'h4000000, 2'd0, 1, 0, 1, 23'h0,      32'hff800000, 0));
        vecs.push_back(mk(8'h7f, 28'h4000000, 2'd0, 1, 1, 1, 23'h012345, 32'hff812345, 0));
        vecs.push_back(mk(8'h7f, 28'h0000000, 2'd0, 1, 0, 0, 23'h0,      32'h80000000, 0));
        vecs.push_back(mk(8'h01, 28'h3fffffc, 2'd0, 0, 0, 0, 23'h0,      32'h00800000, 0));
        vecs.push_back(mk(8'h7f, 28'h7fffffc, 2'd0, 0, 0, 0, 23'h0,      32'h40000000, 0));
        vecs.push_back(mk(8'h7f, 28'h4000004, 2'd1, 0, 0, 0, 23'h0,      32'h3f800000, 0));
        vecs.push_back(mk(8'h7f, 28'h4000006, 2'd0, 0, 0, 0, 23'h0,      32'h3f800001, 0));
        vecs.push_back(mk(8'h7f, 28'h8000004, 2'd2, 0, 0, 0, 23'h0,      32'h40000001, 0));
        vecs.push_back(mk(8'hfe, 28'h8000000, 2'd1, 0, 0, 0, 23'h0,      32'h7f7fffff, 1));
        vecs.push_back(mk(8'hfe, 28'h8000000, 2'd1, 1, 0, 0, 23'h0,      32'hff800000, 1));
        vecs.push_back(mk(8'hfe, 28'h7fffffc, 2'd0, 0, 0, 0, 23'h0,      32'h7f800000, 1));

        // Reset state
        repeat (3) @(posedge clk);
        #1 clrn = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", {32'd0, out_valid}, 33'd0);
        chk("reset_result",    {out_result, out_ovf}, 33'd0);
        chk("reset_in_ready",  {32'd0, in_ready}, 33'd1);

        // Directed vectors, back-to-back, consumer always ready
        @(posedge clk); #1;
        send(vecs[0]);
        @(negedge clk);
        chk("latency_valid", {32'd0, out_valid}, 33'd1);
        @(posedge clk); #1;
        foreach (vecs[i]) send(vecs[i]);
        repeat (3) @(posedge clk);
        #1;

        // Backpressure: two accepted, third waits until the consumer drains
        out_ready = 1'b0;
        send(vecs[0]);
        send(vecs[1]);
        fork
            send(vecs[3]);
            begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", {32'd0, in_ready}, 33'd0);
                    chk("stall_hold",     {out_result, out_valid}, {32'h40000000, 1'b1});
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        chk("stall_drained", {32'd0, 1'(sb.size() != 0)}, 33'd0);

        // Flush with main + skid full, then a same-cycle input is dropped
        out_ready = 1'b0;
        send(vecs[1]);
        send(vecs[2]);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("flush_out_valid", {32'd0, out_valid}, 33'd0);
        chk("flush_in_ready",  {32'd0, in_ready}, 33'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        send(vecs[4]);
        flush = 1'b0;
        @(negedge clk);
        chk("flush_drop_input", {32'd0, out_valid}, 33'd0);

        // Reset mid-operation with main + skid full
        @(posedge clk); #1;
        send(vecs[5]);
        send(vecs[6]);
        clrn = 1'b0;
        @(posedge clk); #1;
        clrn = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
        chk("rst_in_ready",  {32'd0, in_ready}, 33'd1);
        chk("rst_result",    {out_result, out_ovf}, 33'd0);

        // Stream with random backpressure: order and completeness
        @(posedge clk); #1;
        rand_rdy = 1'b1;
        for (int r = 0; r < 3; r++)
            foreach (vecs[i]) send(vecs[i]);
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        #1;
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        chk("stream_drained", {1'b0, 32'(sb.size())}, 33'd0);
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
